bcd_serial_add_ctrl: RTL

// - Sequences a single-digit BCD adder over a DIGITS-wide packed-BCD operand pair, one digit per clock, LSD first.
// - Carry is chained through a register; one 4-bit correction stage serves all digits.
// - Start/busy/done handshake; sits between a register file / keypad front end and a BCD display or accumulator.
//

---
 rtl/bcd_serial_add_ctrl.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/bcd_serial_add_ctrl.sv
// Serial packed-BCD adder controller: one digit per clock, LSD first, carry chained in a register.
// Optional macro BCD_DIGIT_CHECK_EN adds a sticky err output flagging latched digits above 9.
module bcd_serial_add_ctrl #(
    parameter int unsigned DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    input  logic                  cin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   sum,
    output logic                  cout
`ifdef BCD_DIGIT_CHECK_EN
    ,
    output logic                  err
`endif
);

    localparam int unsigned W     = 4 * DIGITS;
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [W-1:0]     sum_q, sum_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef BCD_DIGIT_CHECK_EN
    logic             err_q, err_d;
`endif

    logic [4:0] t_raw;
    logic [4:0] t_adj;
    logic [3:0] digit;
    logic       carry_nxt;

    // Single correction stage; operands sit in shift registers so digit 0 is always the LSBs.
    always_comb begin
        t_raw = {1'b0, a_q[3:0]} + {1'b0, b_q[3:0]} + {4'b0000, carry_q};
        t_adj = t_raw + 5'd6;
        if (t_raw > 5'd9) begin
            digit     = t_adj[3:0];
            carry_nxt = 1'b1;
        end else begin
            digit     = t_raw[3:0];
            carry_nxt = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
`ifdef BCD_DIGIT_CHECK_EN
        err_d   = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    idx_d   = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    busy_d  = 1'b1;
`ifdef BCD_DIGIT_CHECK_EN
                    err_d   = 1'b0;
`endif
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                sum_d[{idx_q, 2'b00} +: 4] = digit;
                carry_d = carry_nxt;
                a_d     = a_q >> 4;
                b_d     = b_q >> 4;
                idx_d   = idx_q + 1'b1;
`ifdef BCD_DIGIT_CHECK_EN
                if ((a_q[3:0] > 4'd9) || (b_q[3:0] > 4'd9)) begin
                    err_d = 1'b1;
                end
`endif
                if (idx_q == LAST_IDX) begin
                    cout_d  = carry_nxt;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef BCD_DIGIT_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef BCD_DIGIT_CHECK_EN
            err_q   <= err_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
`ifdef BCD_DIGIT_CHECK_EN
    assign err  = err_q;
`endif

endmodule
